// File: rtl/idc_host.sv
// Host-side driver for the image controller: buffers an 8x8 frame plus op slots, streams
// them out, then collects 16 results. Optional checksum accumulator: IDC_HOST_CHECKSUM_EN.
module idc_host #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [6:0]  cfg_wdata,
  input  logic        start,
  output logic        in_valid,
  output logic [6:0]  in_data,
  output logic [3:0]  op,
  input  logic        out_valid,
  input  logic [6:0]  out_data,
  input  logic [3:0]  rd_addr,
  output logic [6:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [10:0] checksum
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FIN} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t          state_q;
  logic [5:0]      cnt_q;
  logic [3:0]      k_q;
  logic [TW-1:0]   timer_q;
  logic            iv_q, done_q, terr_q;
  logic [6:0]      idata_q;
  logic [3:0]      op_q;
  logic [6:0]      pix_q [64];
  logic [3:0]      ops_q [15];
  logic [6:0]      res_q [16];

  logic            wr_pix, wr_op;
  logic [6:0]      pix0_d;
  logic [3:0]      op0_d;
  logic [5:0]      cnt_d;
  logic [10:0]     out_sext;

  // Op slots 64..78 decode straight from the low nibble of the address.
  assign wr_pix   = cfg_we && !cfg_addr[6];
  assign wr_op    = cfg_we && (cfg_addr[6:4] == 3'b100) && (cfg_addr[3:0] != 4'hF);
  // A write coinciding with start must be visible in the very first beat.
  assign pix0_d   = (wr_pix && cfg_addr[5:0] == 6'd0) ? cfg_wdata : pix_q[0];
  assign op0_d    = (wr_op && cfg_addr[3:0] == 4'd0) ? cfg_wdata[3:0] : ops_q[0];
  assign cnt_d    = cnt_q + 6'd1;
  assign out_sext = {{4{out_data[6]}}, out_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      timer_q <= '0;
      iv_q    <= 1'b0;
      idata_q <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      for (int i = 0; i < 64; i++) pix_q[i] <= '0;
      for (int i = 0; i < 15; i++) ops_q[i] <= '0;
      for (int i = 0; i < 16; i++) res_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_pix) pix_q[cfg_addr[5:0]] <= cfg_wdata;
          if (wr_op)  ops_q[cfg_addr[3:0]] <= cfg_wdata[3:0];
          if (start) begin
            state_q <= SEND;
            cnt_q   <= '0;
            k_q     <= '0;
            terr_q  <= 1'b0;
            iv_q    <= 1'b1;
            idata_q <= pix0_d;
            op_q    <= op0_d;
          end
        end
        SEND: begin
          if (cnt_q == 6'd63) begin
            state_q <= WAIT;
            iv_q    <= 1'b0;
            idata_q <= '0;
            op_q    <= '0;
            timer_q <= '0;
          end else begin
            cnt_q   <= cnt_d;
            idata_q <= pix_q[cnt_d];
            op_q    <= (cnt_d < 6'd15) ? ops_q[cnt_d[3:0]] : 4'd0;
          end
        end
        WAIT: begin
          if (out_valid) begin
            res_q[0] <= out_data;
            k_q      <= 4'd1;
            state_q  <= RECV;
          end else if (timer_q == TLAST) begin
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RECV: begin
          if (out_valid) begin
            res_q[k_q] <= out_data;
            k_q        <= k_q + 4'd1;
            if (k_q == 4'd15) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IDC_HOST_CHECKSUM_EN
  logic [10:0] chk_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      chk_q <= '0;
    else if (state_q == IDLE && start)
      chk_q <= '0;
    else if ((state_q == WAIT || state_q == RECV) && out_valid)
      chk_q <= chk_q + out_sext;
  end
  assign checksum = chk_q;
`else
  logic unused_sext;
  assign unused_sext = ^out_sext;
  assign checksum    = '0;
`endif

  assign in_valid    = iv_q;
  assign in_data     = idata_q;
  assign op          = op_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign rd_data     = res_q[rd_addr];

endmodule

// File: doc/idc_host.md
IDC_HOST -- requirements
Module: idc_host

Interface
REQ-001 Parameter TIMEOUT, default 1000: maximum idle cycles allowed in WAIT before the first out_valid.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cfg_we  input  1  buffer write strobe.
REQ-005 cfg_addr  input  7  0-63 = pixel index (row-major, 8x8); 64-78 = op slot 0-14; 79-127 = ignored.
REQ-006 cfg_wdata  input  7  write data; op slots store bits [3:0].
REQ-007 start  input  1  single-cycle request to run one transaction.
REQ-008 in_valid  output  1  pixel/op stream valid toward the image controller.
REQ-009 in_data  output  7  signed pixel.
REQ-010 op  output  4  operation code.
REQ-011 out_valid  input  1  result stream valid from the image controller.
REQ-012 out_data  input  7  signed result pixel.
REQ-013 rd_addr  input  4  result readback index.
REQ-014 rd_data  output  7  result[rd_addr], combinational.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when 16 results have been captured.
REQ-017 timeout_err  output  1  sticky; cleared by the next accepted start.
REQ-018 checksum  output  11  signed sum of the 16 captured results.

Function
REQ-019 The FSM states are IDLE, SEND, WAIT, RECV and FIN; it is registered, with a single next-state block.
REQ-020 IDLE: a cfg_we write updates the buffer; start moves to SEND and clears cnt, result count and timeout_err.
REQ-021 If start and cfg_we coincide in IDLE, the write lands first, so SEND transmits the updated value.
REQ-022 In all non-IDLE states, start and cfg_we are ignored and the buffers stay unchanged.
REQ-023 SEND lasts exactly 64 cycles with in_valid=1 and in_data=pixel[cnt].
REQ-024 During SEND, op=op_slot[cnt] for cnt<15 and op=0 for cnt>=15; cnt increments each cycle.
REQ-025 The first in_valid occurs the cycle after start is sampled; in_valid is never de-asserted mid-frame.
REQ-026 After cnt=63, SEND moves to WAIT; in_valid, in_data and op are registered and are 0 outside SEND.
REQ-027 WAIT: a timer counts from 0; if out_valid=1, capture result[0] and move to RECV.
REQ-028 In WAIT, if the timer reaches TIMEOUT-1 without out_valid, set timeout_err=1 and return to IDLE with no done pulse.
REQ-029 RECV: each out_valid=1 cycle stores out_data into result[k] and increments k.
REQ-030 out_valid low cycles in RECV are tolerated without a timeout.
REQ-031 When the 16th value is stored (k=15), move to FIN; FIN pulses done=1 for one cycle and returns to IDLE.
REQ-032 out_valid in IDLE, SEND or FIN is ignored; results are not overwritten.
REQ-033 rd_data holds the last completed captures until the next transaction overwrites them.
REQ-034 Arithmetic is two's complement; pixel and op values are passed through unmodified (op codes 9-15 are sent as stored).

Reset
REQ-035 rst forces IDLE and clears cnt, k, timer, the pixel/op/result buffers, in_valid, in_data, op, busy, done, timeout_err and checksum to 0.
REQ-036 rst asserted mid-SEND or mid-RECV drops in_valid asynchronously and aborts the transaction with no done pulse.

Configuration
REQ-037 With IDC_HOST_CHECKSUM_EN defined, checksum accumulates each captured out_data (sign-extended to 11 bits) during RECV and is cleared on start.
REQ-038 Without IDC_HOST_CHECKSUM_EN, the checksum port exists and is tied to 0, and no accumulator is built.

Verification
REQ-039 Load pixel[i]=i-32, op slots all 4, start; in_valid shall be high for exactly 64 cycles, with in_data -32..31 and op=4 for the first 15 cycles, then 0.
REQ-040 Model responds 20 cycles after the frame with 16 values 1..16 on consecutive cycles; done pulses once, rd_data[rd_addr=15]=16, and checksum=136 with the macro (0 without).
REQ-041 TIMEOUT=50, model never responds; timeout_err=1 exactly 50 cycles into WAIT, busy=0, no done; the next start clears timeout_err.
REQ-042 Model returns 16 values with out_valid gaps of 3 cycles; all 16 are captured in order and done pulses after the last one.
REQ-043 cfg_we/start pulses during SEND are ignored and the frame stays unchanged; rst pulsed at SEND cycle 30 gives in_valid=0 immediately, state IDLE, results all 0.
